tube_ctrl: RTL and testbench

TUBE_CTRL -- requirements
Module: tube_ctrl

---
 rtl/tube_pkg.sv | 49 ++++
 rtl/tube_hex7seg.sv | 11 +
 rtl/tube_ctrl.sv | 172 +++++++++++++++++
 tb/tb_tube_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// Shared constants for the multiplexed seven-segment tube controller:
// register map, CTRL bit positions, segment encoding and blank/off patterns.
package tube_pkg;

  // Register select values seen on addr
  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_AUX  = 2'd1,
    ADDR_CTRL = 2'd2,
    ADDR_RSVD = 2'd3
  } reg_addr_e;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_BLANK = 1;

  // CTRL comes out of reset with scanning enabled and blanking off
  localparam logic [1:0] CTRL_RESET = 2'b01;

  // Segment patterns (active-low): a suppressed leading zero and a
  // disabled/reset display both show every segment dark
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_OFF   = 8'hFF;

  // Hex digit to {dp,g,f,e,d,c,b,a}, active-low, dp always dark
  function automatic logic [7:0] seg_encode(input logic [3:0] nibble);
    logic [7:0] seg;
    case (nibble)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/tube_hex7seg.sv
// Combinational hex nibble to seven-segment decoder.
module hex7seg
  import tube_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg
);

  assign seg = seg_encode(nibble);

endmodule

// File: rtl/tube_ctrl.sv
// Register-programmed driver for two 4-digit multiplexed tubes (DATA low
// and high halves) plus one single-digit tube (AUX). Digits are scanned
// one at a time, each held for SCAN_DIV clocks; all outputs are registered.
module tube_ctrl
  import tube_pkg::*;
#(
  parameter int SCAN_DIV = 25000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [7:0]  digital_tube0,
  output logic [7:0]  digital_tube1,
  output logic [3:0]  digital_tube_sel0,
  output logic [3:0]  digital_tube_sel1,
  output logic [7:0]  digital_tube2,
  output logic        digital_tube_sel2
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  // Programmable registers
  logic [31:0] data_reg;
  logic [3:0]  aux_reg;
  logic [1:0]  ctrl_reg;

  // Scan state
  logic [15:0] div_reg;
  logic [1:0]  idx_reg;

  // Registered display outputs
  logic [7:0]  tube0_reg;
  logic [7:0]  tube1_reg;
  logic [7:0]  tube2_reg;
  logic [3:0]  sel0_reg;
  logic [3:0]  sel1_reg;
  logic        sel2_reg;

  logic        wr_data;
  logic        wr_aux;
  logic        wr_ctrl;
  logic        en_next;

  logic [3:0]  digit [8];
  logic [7:0]  blank_digit;
  logic [3:0]  lo_nib;
  logic [3:0]  hi_nib;
  logic        blank_lo;
  logic        blank_hi;
  logic [7:0]  seg_lo;
  logic [7:0]  seg_hi;
  logic [7:0]  seg_aux;

  assign wr_data = we && (addr == ADDR_DATA);
  assign wr_aux  = we && (addr == ADDR_AUX);
  assign wr_ctrl = we && (addr == ADDR_CTRL);

  // EN as it will be after this edge, so a write that clears EN on the
  // wrap edge stops the scan instead of advancing the digit first
  assign en_next = wr_ctrl ? wdata[CTRL_EN] : ctrl_reg[CTRL_EN];

  // Split DATA into eight hex digits; digit k is a leading zero when it
  // and every digit above it are zero. Digit 0 always shows.
  assign blank_digit[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      assign digit[gi] = data_reg[4*gi +: 4];
    end
    for (genvar gi = 1; gi < 8; gi++) begin : g_blank
      assign blank_digit[gi] = (data_reg[31:4*gi] == '0);
    end
  endgenerate

  // Tube 0 shows digits 0..3, tube 1 shows digits 4..7, same idx on both
  assign lo_nib   = digit[{1'b0, idx_reg}];
  assign hi_nib   = digit[{1'b1, idx_reg}];
  assign blank_lo = ctrl_reg[CTRL_BLANK] && blank_digit[{1'b0, idx_reg}];
  assign blank_hi = ctrl_reg[CTRL_BLANK] && blank_digit[{1'b1, idx_reg}];

  hex7seg u_seg_lo (
    .nibble (lo_nib),
    .seg    (seg_lo)
  );

  hex7seg u_seg_hi (
    .nibble (hi_nib),
    .seg    (seg_hi)
  );

  hex7seg u_seg_aux (
    .nibble (aux_reg),
    .seg    (seg_aux)
  );

  // Register file writes; the reserved address has no storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_reg <= '0;
      aux_reg  <= '0;
      ctrl_reg <= CTRL_RESET;
    end else begin
      if (wr_data) data_reg <= wdata;
      if (wr_aux)  aux_reg  <= wdata[3:0];
      if (wr_ctrl) ctrl_reg <= wdata[1:0];
    end
  end

  // Scan divider and digit index; held at 0 while disabled, so the first
  // enabled cycle starts a full hold period on digit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg <= '0;
      idx_reg <= '0;
    end else if (!ctrl_reg[CTRL_EN] || !en_next) begin
      div_reg <= '0;
      idx_reg <= '0;
    end else if (div_reg == DIV_LAST) begin
      div_reg <= '0;
      idx_reg <= idx_reg + 2'd1;
    end else begin
      div_reg <= div_reg + 16'd1;
    end
  end

  // Output stage: decode the current digit one cycle after the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tube0_reg <= SEG_OFF;
      tube1_reg <= SEG_OFF;
      tube2_reg <= SEG_OFF;
      sel0_reg  <= '0;
      sel1_reg  <= '0;
      sel2_reg  <= 1'b0;
    end else if (!ctrl_reg[CTRL_EN]) begin
      tube0_reg <= SEG_OFF;
      tube1_reg <= SEG_OFF;
      tube2_reg <= SEG_OFF;
      sel0_reg  <= '0;
      sel1_reg  <= '0;
      sel2_reg  <= 1'b0;
    end else begin
      tube0_reg <= blank_lo ? SEG_BLANK : seg_lo;
      tube1_reg <= blank_hi ? SEG_BLANK : seg_hi;
      tube2_reg <= seg_aux;
      sel0_reg  <= 4'b0001 << idx_reg;
      sel1_reg  <= 4'b0001 << idx_reg;
      sel2_reg  <= 1'b1;
    end
  end

  // Register readback, zero-extended
  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA: rdata = data_reg;
      ADDR_AUX:  rdata = {28'd0, aux_reg};
      ADDR_CTRL: rdata = {30'd0, ctrl_reg};
      default:   rdata = '0;
    endcase
  end

  assign digital_tube0     = tube0_reg;
  assign digital_tube1     = tube1_reg;
  assign digital_tube2     = tube2_reg;
  assign digital_tube_sel0 = sel0_reg;
  assign digital_tube_sel1 = sel1_reg;
  assign digital_tube_sel2 = sel2_reg;

endmodule

// File: tb/tb_tube_ctrl.sv
// Self-checking bench for tube_ctrl with a short scan period.
module tb_tube_ctrl;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  digital_tube0;
  logic [7:0]  digital_tube1;
  logic [3:0]  digital_tube_sel0;
  logic [3:0]  digital_tube_sel1;
  logic [7:0]  digital_tube2;
  logic        digital_tube_sel2;

  int checks = 0;
  int errors = 0;

  tube_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk               (clk),
    .reset             (reset),
    .we                (we),
    .addr              (addr),
    .wdata             (wdata),
    .rdata             (rdata),
    .digital_tube0     (digital_tube0),
    .digital_tube1     (digital_tube1),
    .digital_tube_sel0 (digital_tube_sel0),
    .digital_tube_sel1 (digital_tube_sel1),
    .digital_tube2     (digital_tube2),
    .digital_tube_sel2 (digital_tube_sel2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] t0;
    logic [7:0] t1;
    logic [7:0] t2;
    logic [3:0] s0;
    logic [3:0] s1;
    logic       s2;
  } exp_t;

  // Per-digit expectations packed idx3..idx0 (byte 0 = idx 0)
  typedef struct {
    logic [31:0]     data;
    logic [1:0]      ctrl;
    logic [3:0]      aux;
    logic [3:0][7:0] t0;
    logic [3:0][7:0] t1;
    logic [7:0]      t2;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  function automatic exp_t mk(string n, logic [7:0] t0, logic [7:0] t1,
                              logic [7:0] t2, logic [3:0] s, logic s2);
    exp_t e;
    e.name = n;
    e.t0 = t0;
    e.t1 = t1;
    e.t2 = t2;
    e.s0 = s;
    e.s1 = s;
    e.s2 = s2;
    return e;
  endfunction

  function automatic exp_t blank_e(string n);
    return mk(n, 8'hFF, 8'hFF, 8'hFF, 4'b0000, 1'b0);
  endfunction

  task automatic check_out(input exp_t e);
    checks++;
    if (digital_tube0 !== e.t0 || digital_tube1 !== e.t1 || digital_tube2 !== e.t2 ||
        digital_tube_sel0 !== e.s0 || digital_tube_sel1 !== e.s1 ||
        digital_tube_sel2 !== e.s2) begin
      errors++;
      $display("FAIL %s: got t0=%h t1=%h t2=%h s0=%b s1=%b s2=%b, expected t0=%h t1=%h t2=%h s0=%b s1=%b s2=%b",
               e.name, digital_tube0, digital_tube1, digital_tube2, digital_tube_sel0,
               digital_tube_sel1, digital_tube_sel2, e.t0, e.t1, e.t2, e.s0, e.s1, e.s2);
    end
  endtask

  task automatic chk_rd(input logic [1:0] a, input logic [31:0] expv);
    addr = a;
    #1;
    checks++;
    if (rdata !== expv) begin
      errors++;
      $display("FAIL rdata addr%0d: got %h, expected %h", a, rdata, expv);
    end
  endtask

  // One clock; whatever the scoreboard holds for this edge is compared
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_out(e);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    $display("wr addr=%0d data=%h", a, d);
    we = 1'b1;
    addr = a;
    wdata = d;
    step();
    we = 1'b0;
  endtask

  // Stop then re-enable scanning so the next edge starts digit 0 fresh
  task automatic restart(input logic [1:0] ctrl, input string tag);
    wr(2'd2, 32'd0);
    sb_q.push_back(blank_e({tag, " en-edge"}));
    wr(2'd2, {30'd0, ctrl});
  endtask

  // Expect n edges of scanning from digit 0, each digit held SCAN_DIV edges
  task automatic expect_scan(input string tag, input logic [3:0][7:0] t0,
                             input logic [3:0][7:0] t1, input logic [7:0] t2, input int n);
    for (int c = 0; c < n; c++) begin
      int i;
      i = (c / SCAN_DIV) % 4;
      sb_q.push_back(mk($sformatf("%s c%0d", tag, c), t0[i], t1[i], t2, 4'(1 << i), 1'b1));
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 32'h12345678, ctrl: 2'd1, aux: 4'h0, t0: 32'h9282F880, t1: 32'hF9A4B099, t2: 8'hC0};
    vecs[1] = '{data: 32'h000000A0, ctrl: 2'd3, aux: 4'h0, t0: 32'hFFFF88C0, t1: 32'hFFFFFFFF, t2: 8'hC0};
    vecs[2] = '{data: 32'h00050000, ctrl: 2'd3, aux: 4'h5, t0: 32'hC0C0C0C0, t1: 32'hFFFFFF92, t2: 8'h92};
    vecs[3] = '{data: 32'h89ABCDEF, ctrl: 2'd3, aux: 4'hF, t0: 32'hC6A1868E, t1: 32'h80908883, t2: 8'h8E};
    vecs[4] = '{data: 32'h00000000, ctrl: 2'd3, aux: 4'h1, t0: 32'hFFFFFFC0, t1: 32'hFFFFFFFF, t2: 8'hF9};
    vecs[5] = '{data: 32'h10000000, ctrl: 2'd3, aux: 4'h2, t0: 32'hC0C0C0C0, t1: 32'hF9C0C0C0, t2: 8'hA4};
    vecs[6] = '{data: 32'h00000000, ctrl: 2'd1, aux: 4'h4, t0: 32'hC0C0C0C0, t1: 32'hC0C0C0C0, t2: 8'h99};
    vecs[7] = '{data: 32'h0F00B000, ctrl: 2'd3, aux: 4'h7, t0: 32'h83C0C0C0, t1: 32'hFF8EC0C0, t2: 8'hF8};

    // Reset asserted before any clock edge
    #1 reset = 1'b1;
    #2;
    check_out(blank_e("reset pre-edge"));
    @(posedge clk);
    #1;
    check_out(blank_e("reset held"));
    chk_rd(2'd0, 32'd0);
    chk_rd(2'd1, 32'd0);
    chk_rd(2'd2, 32'd1);
    reset = 1'b0;

    // Release: digit 0 first, each digit held SCAN_DIV edges, then wrap
    expect_scan("reset release", 32'hC0C0C0C0, 32'hC0C0C0C0, 8'hC0, 17);

    // Table-driven display patterns
    for (int v = 0; v < 8; v++) begin
      $display("vector %0d data=%h ctrl=%0d aux=%h", v, vecs[v].data, vecs[v].ctrl, vecs[v].aux);
      wr(2'd0, vecs[v].data);
      wr(2'd1, {28'd0, vecs[v].aux});
      restart(vecs[v].ctrl, $sformatf("vec%0d", v));
      expect_scan($sformatf("vec%0d", v), vecs[v].t0, vecs[v].t1, vecs[v].t2, 17);
    end

    // Readback and reserved address
    wr(2'd1, 32'h0000000F);
    wr(2'd2, 32'h00000001);
    chk_rd(2'd1, 32'h0000000F);
    chk_rd(2'd2, 32'h00000001);
    chk_rd(2'd0, 32'h0F00B000);
    wr(2'd3, 32'hFFFFFFFF);
    chk_rd(2'd3, 32'd0);
    chk_rd(2'd2, 32'h00000001);

    // Disable mid-scan, then re-enable
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h12345678);
    restart(2'd1, "A");
    expect_scan("A run", 32'h9282F880, 32'hF9A4B099, 8'hC0, 6);
    sb_q.push_back(mk("A dis-edge", 8'hF8, 8'hB0, 8'hC0, 4'b0010, 1'b1));
    wr(2'd2, 32'd0);
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(blank_e($sformatf("A off%0d", k)));
      step();
    end
    sb_q.push_back(blank_e("A en-edge"));
    wr(2'd2, 32'd1);
    expect_scan("A restart", 32'h9282F880, 32'hF9A4B099, 8'hC0, 5);

    // DATA written on the wrap edge shows at the new digit next edge
    restart(2'd1, "B");
    expect_scan("B pre", 32'h9282F880, 32'hF9A4B099, 8'hC0, 3);
    sb_q.push_back(mk("B wrap-edge", 8'h80, 8'h99, 8'hC0, 4'b0001, 1'b1));
    wr(2'd0, 32'hFFFFFFFF);
    sb_q.push_back(mk("B new0", 8'h8E, 8'h8E, 8'hC0, 4'b0010, 1'b1));
    step();
    sb_q.push_back(mk("B new1", 8'h8E, 8'h8E, 8'hC0, 4'b0010, 1'b1));
    step();
    chk_rd(2'd0, 32'hFFFFFFFF);

    // EN cleared on the wrap edge, then re-enabled: restart at digit 0
    restart(2'd1, "C");
    expect_scan("C pre", 32'h8E8E8E8E, 32'h8E8E8E8E, 8'hC0, 3);
    sb_q.push_back(mk("C wrap-edge", 8'h8E, 8'h8E, 8'hC0, 4'b0001, 1'b1));
    wr(2'd2, 32'd0);
    sb_q.push_back(blank_e("C off"));
    step();
    sb_q.push_back(blank_e("C en-edge"));
    wr(2'd2, 32'd1);
    expect_scan("C restart", 32'h8E8E8E8E, 32'h8E8E8E8E, 8'hC0, 5);

    // Reset pulsed while digit 2 is showing, between clock edges
    wr(2'd0, 32'h12345678);
    restart(2'd1, "D");
    expect_scan("D pre", 32'h9282F880, 32'hF9A4B099, 8'hC0, 9);
    #2;
    reset = 1'b1;
    #1;
    check_out(blank_e("D async reset"));
    @(posedge clk);
    #1;
    check_out(blank_e("D reset held"));
    chk_rd(2'd0, 32'd0);
    chk_rd(2'd2, 32'd1);
    reset = 1'b0;
    expect_scan("D release", 32'hC0C0C0C0, 32'hC0C0C0C0, 8'hC0, 17);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
